// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-event bundle between the scanner and its neighbours.
// master: the scanner (drives columns, reports keys); slave: pins/consumer side.
interface keypad_scanner_if;
  logic [4:7] rows;
  logic [0:3] cols;
  logic [0:7] key_coord;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  rows,
    output cols, key_coord, key_valid, key_held
  );

  modport slave (
    output rows,
    input  cols, key_coord, key_valid, key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: one-hot column drive, synchronised row returns,
// single-key debounce with press pulse and held flag.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SCAN     | rotating columns, looking for exactly one active row
// DEBOUNCE | columns frozen, counting agreeing samples of the capture
// HELD     | key accepted, waiting for rows to go quiet
// RELEASE  | rows quiet, counting quiet samples before letting go
module keypad_scanner #(
  parameter int CLK_FREQ       = 12_000_000,
  parameter int SCAN_HZ        = 1_000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input logic               clk,
  input logic               rst,
  keypad_scanner_if.master  kp
);

  localparam int TICK_DIV = CLK_FREQ / SCAN_HZ;
  localparam int DIV_W    = $clog2(TICK_DIV);
  localparam int CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  logic [4:7]       rows_m_q, rows_s_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [0:3]       cols_q, cols_d, cols_rot;
  logic [4:7]       cap_row_q, cap_row_d;
  logic [0:7]       coord_q, coord_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;
  logic             tick, rows_valid, rows_zero;

  assign tick       = (div_q == DIV_LAST);
  assign rows_zero  = (rows_s_q == 4'b0000);
  assign rows_valid = !rows_zero && ((rows_s_q & (rows_s_q - 4'd1)) == 4'b0000);
  assign cols_rot   = {cols_q[3], cols_q[0:2]};
  assign cnt_inc    = cnt_q + CNT_ONE;

  // Two-flop synchroniser for the asynchronous row returns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rows_m_q <= '0;
      rows_s_q <= '0;
    end else begin
      rows_m_q <= kp.rows;
      rows_s_q <= rows_m_q;
    end
  end

  // Free-running scan tick divider.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          div_q <= '0;
    else if (tick)     div_q <= '0;
    else               div_q <= div_q + DIV_W'(1);
  end

  // Next-state logic; every decision waits for a tick. The column stays
  // frozen while debouncing, so the live column is the captured column.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cols_d    = cols_q;
    cap_row_d = cap_row_q;
    coord_d   = coord_q;
    valid_d   = 1'b0;
    held_d    = held_q;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (rows_valid) begin
            cap_row_d = rows_s_q;
            cnt_d     = CNT_ONE;
            state_d   = DEBOUNCE;
          end else begin
            cols_d = cols_rot;
          end
        end
        DEBOUNCE: begin
          if (rows_s_q == cap_row_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_d = HELD;
              cnt_d   = '0;
              coord_d = {cols_q, cap_row_q};
              valid_d = 1'b1;
              held_d  = 1'b1;
            end
          end else begin
            state_d = SCAN;
            cnt_d   = '0;
            cols_d  = cols_rot;
          end
        end
        HELD: begin
          if (rows_zero) begin
            state_d = RELEASE;
            cnt_d   = CNT_ONE;
          end
        end
        RELEASE: begin
          if (rows_zero) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_d = SCAN;
              cnt_d   = '0;
              held_d  = 1'b0;
              cols_d  = cols_rot;
            end
          end else begin
            state_d = HELD;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = SCAN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM, counter and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= SCAN;
      cnt_q     <= '0;
      cols_q    <= 4'b1000;
      cap_row_q <= '0;
      coord_q   <= '0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cols_q    <= cols_d;
      cap_row_q <= cap_row_d;
      coord_q   <= coord_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
    end
  end

  assign kp.cols      = cols_q;
  assign kp.key_coord = coord_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (TICK_DIV=10, DEBOUNCE_SCANS=4).
module tb_keypad_scanner;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   pulse_cnt = 0;
  int   last_pulse = -1;
  logic prev_valid = 1'b0;

  logic       key_on = 1'b0;
  logic [0:3] key_col = 4'b0000;
  logic [4:7] key_row = 4'b0000;

  keypad_scanner_if kp();

  keypad_scanner #(.CLK_FREQ(100), .SCAN_HZ(10), .DEBOUNCE_SCANS(4)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp.master)
  );

  always #5 clk = ~clk;

  // Keypad matrix model: the pressed key connects its column to its row(s).
  always_comb begin
    kp.rows = 4'b0000;
    if (key_on && ((kp.cols & key_col) != 4'b0000)) kp.rows = key_row;
  end

  // Cycle counter, cleared by reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Pulse monitor: count key_valid pulses and flag back-to-back highs.
  always @(negedge clk) begin
    if (rst && kp.key_valid) begin
      checks++;
      if (prev_valid) begin
        errors++;
        $display("FAIL valid_double at cyc %0d: key_valid high two cycles in a row", cyc);
      end
      pulse_cnt++;
      last_pulse = cyc;
    end
    prev_valid = rst && kp.key_valid;
  end

  task automatic do_reset();
    key_on = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pulse_cnt = 0;
    last_pulse = -1;
  endtask

  task automatic wait_until(input int t);
    for (int n = 0; n < 5000 && cyc < t; n++) @(negedge clk);
    checks++;
    if (cyc !== t) begin
      errors++;
      $display("FAIL wait_bound: cyc=%0d required %0d", cyc, t);
    end
  endtask

  task automatic chk_cols(input string name, input logic [0:3] exp);
    checks++;
    if (kp.cols !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: cols=%b required %b", name, cyc, kp.cols, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({kp.cols, kp.key_coord, kp.key_valid, kp.key_held} !== {4'b1000, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: cols=%b coord=%b valid=%b held=%b required 1000/0/0/0",
               kp.cols, kp.key_coord, kp.key_valid, kp.key_held);
    end
  endtask

  task automatic test_idle_scan();
    int         t_l[6]   = '{9, 10, 20, 30, 39, 40};
    logic [0:3] c_l[6]   = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001, 4'b1000};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wait_until(t_l[i]);
      chk_cols("idle_cols", c_l[i]);
    end
    checks++;
    if ({kp.key_coord, kp.key_valid, kp.key_held} !== 10'b0) begin
      errors++;
      $display("FAIL idle_outputs: coord=%b valid=%b held=%b required 0", kp.key_coord, kp.key_valid, kp.key_held);
    end
    chk_int("idle_pulses", pulse_cnt, 0);
  endtask

  task automatic test_press();
    do_reset();
    key_col = 4'b0010; key_row = 4'b0100; key_on = 1'b1;
    wait_until(59);
    chk_int("press_no_early_pulse", pulse_cnt, 0);
    wait_until(100);
    chk_int("press_pulses", pulse_cnt, 1);
    chk_int("press_latency", last_pulse, 60);
    checks++;
    if (kp.key_coord !== 8'b0010_0100 || kp.key_held !== 1'b1) begin
      errors++;
      $display("FAIL press_coord: coord=%b held=%b required 00100100/1", kp.key_coord, kp.key_held);
    end
    chk_cols("press_frozen", 4'b0010);
  endtask

  task automatic test_bounce();
    do_reset();
    key_col = 4'b0010; key_row = 4'b0100;
    for (int c = 1; c <= 120; c++) begin
      wait_until(c);
      key_on = (c >= 67) || (c >= 25 && ((c - 25) / 7) % 2 == 0);
      if (c == 45) chk_cols("bounce_rescan", 4'b0001);
      if (c == 109) chk_int("bounce_no_pulse", pulse_cnt, 0);
    end
    chk_int("bounce_pulses", pulse_cnt, 1);
    chk_int("bounce_latency", last_pulse, 110);
    checks++;
    if (kp.key_coord !== 8'b0010_0100) begin
      errors++;
      $display("FAIL bounce_coord: coord=%b required 00100100", kp.key_coord);
    end
  endtask

  task automatic test_multi_row();
    do_reset();
    key_col = 4'b1000; key_row = 4'b1010; key_on = 1'b1;
    wait_until(10);
    chk_cols("multi_scan_a", 4'b0100);
    wait_until(50);
    chk_cols("multi_scan_b", 4'b0100);
    wait_until(100);
    chk_int("multi_no_pulse", pulse_cnt, 0);
    key_row = 4'b1000;
    wait_until(200);
    chk_int("single_pulses", pulse_cnt, 1);
    chk_int("single_latency", last_pulse, 160);
    checks++;
    if (kp.key_coord !== 8'b1000_1000) begin
      errors++;
      $display("FAIL single_coord: coord=%b required 10001000", kp.key_coord);
    end
  endtask

  task automatic test_release();
    do_reset();
    key_col = 4'b0010; key_row = 4'b0100; key_on = 1'b1;
    for (int c = 1; c <= 260; c++) begin
      wait_until(c);
      key_on = (c < 100) || (c >= 111 && c <= 118) || (c >= 131 && c <= 138) || (c >= 180);
      if (c == 125) chk_int("release_bounce_held", int'(kp.key_held), 1);
      if (c == 179) begin
        chk_int("release_still_held", int'(kp.key_held), 1);
        chk_int("release_no_extra", pulse_cnt, 1);
      end
      if (c == 180) begin
        chk_int("release_dropped", int'(kp.key_held), 0);
        chk_cols("release_advance", 4'b0001);
      end
    end
    chk_int("repress_pulses", pulse_cnt, 2);
    chk_int("repress_latency", last_pulse, 250);
    chk_int("repress_held", int'(kp.key_held), 1);
  endtask

  task automatic test_reset_in_debounce();
    do_reset();
    key_col = 4'b0010; key_row = 4'b0100; key_on = 1'b1;
    wait_until(45);
    chk_cols("debounce_frozen", 4'b0010);
    rst = 1'b0;
    #1;
    checks++;
    if ({kp.cols, kp.key_coord, kp.key_valid, kp.key_held} !== {4'b1000, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: cols=%b coord=%b valid=%b held=%b required 1000/0/0/0",
               kp.cols, kp.key_coord, kp.key_valid, kp.key_held);
    end
    key_on = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_until(9);
    chk_cols("restart_a", 4'b1000);
    wait_until(10);
    chk_cols("restart_b", 4'b0100);
    chk_int("abort_no_pulse", pulse_cnt, 0);
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_press();
    test_bounce();
    test_multi_row();
    test_release();
    test_reset_in_debounce();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
